alu_nibble_seq: RTL and testbench

ALU_NIBBLE_SEQ -- requirements
Module: alu_nibble_seq

---
 rtl/alu_nibble_seq.sv | 200 ++++++++++++++++++++
 tb/tb_alu_nibble_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// Sequences a W-bit AND/OR/SUB/ADD through an external 4-bit ALU, one nibble per cycle, LSB first.
// Latency: res_valid rises NIBBLES cycles after the accepting edge. Backpressure: op_ready only in IDLE; DONE holds until res_ready.
// Optional signed-overflow output res_v is enabled by defining ALU_NIBBLE_SEQ_OVF_EN.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_sel,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  output logic [1:0]             alu_sel,
  input  logic [3:0]             alu_y,
  input  logic                   alu_cout,
  input  logic                   alu_bout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res,
  output logic                   res_c,
  output logic                   res_z
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  ,
  output logic                   res_v
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_SUB = 2'b10;
  localparam logic [1:0] SEL_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  state_t        state_q;
  state_t        state_d;
  op_t           op_q;
  logic [IW-1:0] idx_q;
  logic          chain_q;
  logic [W-1:0]  res_q;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic          last_nib;
  logic          chain_d;
  logic          is_arith;

  assign last_nib = (idx_q == IW'(NIBBLES - 1));
  assign is_arith = op_q.sel[1];

  // Nibble mux for the current index.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        nib_a = op_q.a[4*n +: 4];
        nib_b = op_q.b[4*n +: 4];
      end
    end
  end

  always_comb begin
    chain_d = 1'b0;
    case (op_q.sel)
      SEL_ADD: chain_d = alu_cout;
      SEL_SUB: chain_d = alu_bout;
      SEL_AND,
      SEL_OR:  chain_d = 1'b0;
      default: chain_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_cin   = 1'b0;
    alu_sel   = SEL_AND;
    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        alu_a   = nib_a;
        alu_b   = nib_b;
        alu_sel = op_q.sel;
        // Nibble 0 takes the external carry/borrow; later nibbles ride the chain.
        if (is_arith) begin
          alu_cin = (idx_q == '0) ? op_q.cin : chain_q;
        end
        if (last_nib) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      idx_q   <= '0;
      chain_q <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            op_q.sel <= op_sel;
            op_q.a   <= op_a;
            op_q.b   <= op_b;
            op_q.cin <= op_cin;
            idx_q    <= '0;
            chain_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
              res_q[4*n +: 4] <= alu_y;
            end
          end
          idx_q   <= idx_q + 1'b1;
          chain_q <= chain_d;
        end
        default: ;
      endcase
    end
  end

  assign res   = res_q;
  assign res_c = chain_q;
  assign res_z = (res_q == '0);

`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Signed overflow judged from operand MSBs and the top result nibble as it is written.
  always_comb begin
    ovf_d = 1'b0;
    case (op_q.sel)
      SEL_ADD: ovf_d = (op_q.a[W-1] == op_q.b[W-1]) && (alu_y[3] != op_q.a[W-1]);
      SEL_SUB: ovf_d = (op_q.a[W-1] != op_q.b[W-1]) && (alu_y[3] != op_q.a[W-1]);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_IDLE && op_valid) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_RUN && last_nib) begin
      ovf_q <= ovf_d;
    end
  end

  assign res_v = ovf_q;
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq with a behavioural 4-bit ALU attached to the nibble port.
module tb_alu_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [1:0]   op_sel;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [1:0]   alu_sel;
  logic [3:0]   alu_y;
  logic         alu_cout;
  logic         alu_bout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res;
  logic         res_c;
  logic         res_z;
`ifdef ALU_NIBBLE_SEQ_OVF_EN
  logic         res_v;
`endif

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_bout(alu_bout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res(res), .res_c(res_c), .res_z(res_z)
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    , .res_v(res_v)
`endif
  );

  // External 4-bit ALU.
  logic [4:0] sum5;
  logic [4:0] dif5;
  always_comb begin
    sum5 = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    dif5 = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_cin};
    case (alu_sel)
      2'b00:   alu_y = alu_a & alu_b;
      2'b01:   alu_y = alu_a | alu_b;
      2'b10:   alu_y = dif5[3:0];
      default: alu_y = sum5[3:0];
    endcase
    alu_cout = sum5[4];
    alu_bout = dif5[4];
  end

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
    logic [3:0]   cins;   // expected alu_cin per nibble, bit i = nibble i
  } vec_t;

  vec_t vecs[12];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE (called at a negedge) and check it through to IDLE again.
  task automatic run_op(input vec_t v, input string tag);
    logic [12:0] exp_drv;
    check({tag, " idle_ready"}, {31'b0, op_ready}, 32'd1);
    op_valid = 1'b1; op_sel = v.sel; op_a = v.a; op_b = v.b; op_cin = v.cin;
    @(posedge clk);
    for (int k = 0; k < NIB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op_sel = ~v.sel; op_a = ~v.a; op_b = ~v.b; op_cin = ~v.cin;
      end
      exp_drv = {v.a[4*k +: 4], v.b[4*k +: 4], v.cins[k], v.sel, 1'b0, 1'b0};
      check($sformatf("%s run_nib%0d", tag, k),
            {19'b0, alu_a, alu_b, alu_cin, alu_sel, res_valid, op_ready}, {19'b0, exp_drv});
    end
    @(negedge clk);
    op_valid = 1'b0;
    check({tag, " done_ctrl"},
          {19'b0, res_valid, op_ready, alu_a, alu_b, alu_cin, alu_sel}, {19'b0, 2'b10, 11'b0});
    check({tag, " res"}, {16'b0, res}, {16'b0, v.res});
    check({tag, " res_cz"}, {30'b0, res_c, res_z}, {30'b0, v.c, v.z});
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    check({tag, " res_v"}, {31'b0, res_v}, {31'b0, v.v});
`endif
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " back_idle"}, {14'b0, res_valid, op_ready, res}, {14'b0, 2'b01, v.res});
  endtask

  int hi_cnt;

  initial begin
    //            sel    a         b         cin   res       c     z     v     cins
    vecs[0]  = '{2'b11, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[1]  = '{2'b11, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 4'b1111};
    vecs[2]  = '{2'b10, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 4'b1110};
    vecs[3]  = '{2'b10, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'b1110};
    vecs[4]  = '{2'b00, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[5]  = '{2'b01, 16'hF0F0, 16'hFF00, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[6]  = '{2'b11, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{2'b10, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'b0000};
    vecs[8]  = '{2'b11, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'b0000};
    vecs[9]  = '{2'b10, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[10] = '{2'b11, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 4'b1110};
    vecs[11] = '{2'b10, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1, 4'b1110};

    rst_n = 1'b0; op_valid = 1'b0; op_sel = 2'b00; op_a = '0; op_b = '0; op_cin = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ctrl", {30'b0, op_ready, res_valid}, {30'b0, 2'b10});
    check("reset res", {16'b0, res}, 32'h0);
    check("reset res_cz", {30'b0, res_c, res_z}, {30'b0, 2'b01});
    check("reset alu_bus", {21'b0, alu_a, alu_b, alu_cin, alu_sel}, 32'h0);
`ifdef ALU_NIBBLE_SEQ_OVF_EN
    check("reset res_v", {31'b0, res_v}, 32'h0);
`endif

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Hold in DONE with res_ready low while op_valid is pushed.
    op_valid = 1'b1; op_sel = 2'b11; op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_a = 16'hAAAA; op_b = 16'h5555; op_sel = 2'b10;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold cyc%0d", k), {14'b0, res_valid, op_ready, res}, {14'b0, 2'b10, 16'h5555});
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("release same_edge", {14'b0, res_valid, op_ready, res}, {14'b0, 2'b01, 16'h5555});
    op_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("release no_accept", {30'b0, op_ready, res_valid}, {30'b0, 2'b10});

    // Reset pulse at nibble index 2 of an ADD.
    op_valid = 1'b1; op_sel = 2'b11; op_a = 16'h1234; op_b = 16'h4321; op_cin = 1'b0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset res", {16'b0, res}, 32'h0);
    check("midrun reset flags", {30'b0, res_valid, res_c}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; op_valid = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (res_valid) hi_cnt++;
    end
    check("post_reset no_valid", hi_cnt, 32'd0);
    check("post_reset idle", {15'b0, op_ready, res}, {15'b0, 1'b1, 16'h0});
    run_op(vecs[0], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
